led_chaser: RTL and testbench
=============================

LED_CHASER -- requirements
Module: led_chaser

Interface
REQ-001 Parameter WIDTH, default 8, number of LED outputs; SHALL be >= 1.
REQ-002 Parameter STEP_CYCLES, default 50000000, clk cycles per display step; SHALL be >= 1.
REQ-003 Parameter CNT_W, default 26, prescaler width; SHALL satisfy 2^CNT_W > STEP_CYCLES-1.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  step enable; low freezes prescaler and display.
REQ-007 mode  input  2  pattern select: 00 rotate-left, 01 rotate-right, 10 bounce, 11 fill-bar.
REQ-008 LED  output  WIDTH  registered LED pattern.
REQ-009 step  output  1  registered one-cycle pulse marking each display update.

Function
REQ-010 Prescaler cnt SHALL count 0..STEP_CYCLES-1 while en=1, then wrap to 0; while en=0 it SHALL hold its value.
REQ-011 A tick SHALL occur on an edge where en=1 and cnt==STEP_CYCLES-1; with STEP_CYCLES=1 every enabled edge is a tick.
REQ-012 Internal state: pos (0..WIDTH-1), dir (up/down); pos, dir and LED SHALL change only on tick edges.
REQ-013 mode SHALL be sampled only on tick edges; changes between ticks SHALL have no effect until the next tick; pos is retained across mode changes.
REQ-014 Rotate-left: pos -> pos+1, WIDTH-1 wraps to 0; dir set up.
REQ-015 Rotate-right: pos -> pos-1, 0 wraps to WIDTH-1; dir set down.
REQ-016 Bounce: dir up and pos==WIDTH-1 -> dir down, pos WIDTH-2; dir down and pos==0 -> dir up, pos 1; otherwise move one place in dir; each endpoint SHALL be shown for exactly one step.
REQ-017 Fill-bar: pos advances as rotate-left; dir set up.
REQ-018 On a tick edge LED SHALL take the decode of the new pos under the sampled mode: modes 00/01/10 one-hot bit[pos]; mode 11 bits [pos:0] set, others clear.
REQ-019 Latency: LED and step SHALL change on the same edge as the tick (the edge on which cnt==STEP_CYCLES-1 is observed); step high for exactly that following cycle, 0 otherwise.
REQ-020 WIDTH=1: pos SHALL stay 0, LED SHALL stay 1 in all modes; step SHALL still pulse on ticks.
REQ-021 en deasserted mid-step SHALL resume counting from the held cnt value, preserving the remaining step length.
REQ-022 Tick cadence SHALL be exactly STEP_CYCLES enabled cycles apart, independent of mode.

Reset
REQ-023 On an edge with reset=1: cnt=0, pos=0, dir=up, LED=1 (bit 0 only), step=0.
REQ-024 reset SHALL override en, tick and mode on the same edge; no step pulse SHALL be produced.
REQ-025 Reset asserted mid-operation SHALL restore REQ-023 state within one edge regardless of mode, pos or dir.
REQ-026 First tick after reset release SHALL occur STEP_CYCLES enabled edges later.

Verification (WIDTH=8, STEP_CYCLES=4, CNT_W=2)
REQ-027 Reset, en=1, mode=00 -> LED 0x01,0x02,0x04,...,0x80,0x01, each held 4 cycles; step pulses every 4th cycle.
REQ-028 Reset, mode=01 -> LED 0x01,0x80,0x40,0x20,...; wrap 0x01->0x80 observed.
REQ-029 Reset, mode=10 -> LED 0x01,0x02,...,0x80,0x40,...,0x01,0x02; 0x80 and 0x01 each held exactly one step.
REQ-030 Reset, mode=11 -> LED 0x01,0x03,0x07,0x0F,...,0xFF,0x01.
REQ-031 mode=00, en dropped 10 cycles after cnt=2 -> LED, cnt frozen, no step; tick 2 enabled cycles after en returns; mode toggled between ticks -> ignored until tick.
REQ-032 mode=10 at LED=0x20 moving down, reset pulsed one cycle coinciding with a tick -> next cycle LED=0x01, step=0, cnt=0; next step LED=0x02.

Source files
------------

// File: rtl/led_chaser.sv
// LED chaser: a prescaler divides clk into display steps, and on each step
// a position/direction pair advances under the selected pattern mode. The
// new position is then decoded onto the LED outputs.
module led_chaser #(
    parameter int WIDTH       = 8,
    parameter int STEP_CYCLES = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] LED,
    output logic             step
);

    localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    typedef enum logic [1:0] {
        MODE_ROL    = 2'b00,
        MODE_ROR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] pos_next;
    dir_t             dir;
    dir_t             dir_next;
    logic [WIDTH-1:0] led_next;
    logic [WIDTH-1:0] one_hot;
    logic [WIDTH-1:0] fill;
    logic             tick;
    mode_t            mode_sel;

    assign mode_sel = mode_t'(mode);

    // State register: prescaler, position, direction and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            pos  <= '0;
            dir  <= DIR_UP;
            LED  <= WIDTH'(1);
            step <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            pos  <= pos_next;
            dir  <= dir_next;
            LED  <= led_next;
            step <= tick;
        end
    end

    // Prescaler and tick generation; cnt holds while en is low.
    always_comb begin
        tick     = en && (cnt == CNT_LAST);
        cnt_next = cnt;
        if (en) begin
            cnt_next = tick ? '0 : cnt + 1'b1;
        end
    end

    // Next position/direction; mode is only consulted on a tick.
    always_comb begin
        pos_next = pos;
        dir_next = dir;
        if (tick) begin
            unique case (mode_sel)
                MODE_ROL, MODE_FILL: begin
                    pos_next = (pos == POS_LAST) ? '0 : pos + 1'b1;
                    dir_next = DIR_UP;
                end
                MODE_ROR: begin
                    pos_next = (pos == '0) ? POS_LAST : pos - 1'b1;
                    dir_next = DIR_DOWN;
                end
                MODE_BOUNCE: begin
                    if (WIDTH == 1) begin
                        pos_next = '0;
                    end else if (dir == DIR_UP) begin
                        if (pos == POS_LAST) begin
                            dir_next = DIR_DOWN;
                            pos_next = POS_LAST - POS_ONE;
                        end else begin
                            pos_next = pos + 1'b1;
                        end
                    end else begin
                        if (pos == '0) begin
                            dir_next = DIR_UP;
                            pos_next = POS_ONE;
                        end else begin
                            pos_next = pos - 1'b1;
                        end
                    end
                end
                default: begin
                    pos_next = pos;
                    dir_next = dir;
                end
            endcase
        end
    end

    // Decode the new position into one-hot and bar patterns.
    always_comb begin
        one_hot = '0;
        fill    = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            one_hot[i] = (POS_W'(i) == pos_next);
            fill[i]    = (POS_W'(i) <= pos_next);
        end
    end

    // LED only updates on a tick, using the mode sampled on that edge.
    always_comb begin
        led_next = LED;
        if (tick) begin
            led_next = (mode_sel == MODE_FILL) ? fill : one_hot;
        end
    end

endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench for led_chaser: vector table, hand-written corner
// sequences, and randomized stimulus against a phase-based reference model.
module tb_led_chaser;

    localparam int W = 8;
    localparam int S = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic [W-1:0] led;
    logic         step;
    logic [0:0]   led1;
    logic         step1;

    led_chaser #(.WIDTH(W), .STEP_CYCLES(S), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .LED(led), .step(step)
    );

    led_chaser #(.WIDTH(1), .STEP_CYCLES(1), .CNT_W(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .LED(led1), .step(step1)
    );

    always #5 clk = ~clk;

    int nchk  = 0;
    int nfail = 0;

    // Reference model: bounce handled as a phase around a ring of 2W-2.
    int         m_cnt = 0;
    int         m_pos = 0;
    bit         m_up  = 1'b1;
    logic [7:0] m_led = 8'h01;
    logic       m_step = 1'b0;
    logic       m1_step = 1'b0;

    typedef struct {
        logic       r;
        logic       e;
        logic [1:0] m;
        logic [7:0] led;
        logic       s;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic [1:0] m);
        bit tk;
        int ph;
        int v;
        m1_step = !r && e;
        if (r) begin
            m_cnt = 0; m_pos = 0; m_up = 1'b1; m_led = 8'h01; m_step = 1'b0;
        end else begin
            tk = e && (m_cnt == S - 1);
            if (e) m_cnt = (m_cnt + 1) % S;
            m_step = tk;
            if (tk) begin
                case (m)
                    2'd0, 2'd3: begin m_pos = (m_pos + 1) % W; m_up = 1'b1; end
                    2'd1:       begin m_pos = (m_pos + W - 1) % W; m_up = 1'b0; end
                    default: begin
                        ph    = m_up ? m_pos : (2*W - 2 - m_pos);
                        ph    = (ph + 1) % (2*W - 2);
                        m_pos = (ph < W) ? ph : (2*W - 2 - ph);
                        m_up  = (ph < W - 1);
                    end
                endcase
                v = (m == 2'd3) ? ((1 << (m_pos + 1)) - 1) : (1 << m_pos);
                m_led = v[7:0];
            end
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] m);
        reset = r; en = e; mode = m;
        @(posedge clk);
        model_step(r, e, m);
        #1;
    endtask

    task automatic add_vec(input logic r, input logic e, input logic [1:0] m,
                           input logic [7:0] l, input logic s);
        vec_t v;
        v.r = r; v.e = e; v.m = m; v.led = l; v.s = s;
        vecs.push_back(v);
    endtask

    // One reset cycle followed by the given display steps in one mode.
    task automatic add_seq(input logic [1:0] m, input logic [7:0] seq[$]);
        logic [7:0] prev;
        add_vec(1'b1, 1'b1, 2'd3, 8'h01, 1'b0);
        prev = 8'h01;
        foreach (seq[k]) begin
            repeat (S - 1) add_vec(1'b0, 1'b1, m, prev, 1'b0);
            add_vec(1'b0, 1'b1, m, seq[k], 1'b1);
            prev = seq[k];
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic       r;
        logic       e;
        logic [1:0] m;

        q = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        add_seq(2'd0, q);
        q = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
        add_seq(2'd1, q);
        q = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        add_seq(2'd2, q);
        q = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01, 8'h03};
        add_seq(2'd3, q);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].e, vecs[i].m);
            chk($sformatf("vec%0d_led", i), 16'(led), 16'(vecs[i].led));
            chk($sformatf("vec%0d_step", i), 16'(step), 16'(vecs[i].s));
        end

        // en dropped at cnt=2: everything freezes, tick two enabled edges later
        drive(1'b1, 1'b0, 2'd0);
        chk("frz_reset_led", 16'(led), 16'h01);
        drive(1'b0, 1'b1, 2'd0);
        drive(1'b0, 1'b1, 2'd0);
        repeat (10) begin
            drive(1'b0, 1'b0, 2'd0);
            chk("frz_led", 16'(led), 16'h01);
            chk("frz_step", 16'(step), 16'h0);
        end
        drive(1'b0, 1'b1, 2'd0);
        chk("resume1_led", 16'(led), 16'h01);
        chk("resume1_step", 16'(step), 16'h0);
        drive(1'b0, 1'b1, 2'd0);
        chk("resume2_led", 16'(led), 16'h02);
        chk("resume2_step", 16'(step), 16'h1);
        // mode wiggled between ticks has no effect; only the tick-edge mode counts
        drive(1'b0, 1'b1, 2'd1);
        chk("tog1_led", 16'(led), 16'h02);
        drive(1'b0, 1'b1, 2'd3);
        chk("tog2_led", 16'(led), 16'h02);
        drive(1'b0, 1'b1, 2'd2);
        chk("tog3_led", 16'(led), 16'h02);
        drive(1'b0, 1'b1, 2'd0);
        chk("tog_tick_led", 16'(led), 16'h04);
        chk("tog_tick_step", 16'(step), 16'h1);

        // bounce at 0x20 moving down, reset lands on a tick edge
        drive(1'b1, 1'b0, 2'd2);
        repeat (9 * S) drive(1'b0, 1'b1, 2'd2);
        chk("bnc_down_led", 16'(led), 16'h20);
        repeat (S - 1) drive(1'b0, 1'b1, 2'd2);
        chk("bnc_pre_led", 16'(led), 16'h20);
        drive(1'b1, 1'b1, 2'd2);
        chk("rst_tick_led", 16'(led), 16'h01);
        chk("rst_tick_step", 16'(step), 16'h0);
        repeat (S - 1) begin
            drive(1'b0, 1'b1, 2'd2);
            chk("post_rst_led", 16'(led), 16'h01);
            chk("post_rst_step", 16'(step), 16'h0);
        end
        drive(1'b0, 1'b1, 2'd2);
        chk("post_rst_tick_led", 16'(led), 16'h02);
        chk("post_rst_tick_step", 16'(step), 16'h1);

        // randomized run against the reference model (both widths)
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 3) != 0);
            m = 2'($urandom_range(0, 3));
            drive(r, e, m);
            chk("rnd_led", 16'(led), 16'(m_led));
            chk("rnd_step", 16'(step), 16'(m_step));
            chk("rnd_w1_led", 16'(led1), 16'h1);
            chk("rnd_w1_step", 16'(step1), 16'(m1_step));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
